// File: rtl/cam_sequencer.sv
// Purpose : IR camera bring-up (reset pulse, settle, 6-entry config write) then periodic position reads.
// Latency : first write RESET_CYCLES+SETTLE_CYCLES+1 cycles after start; one read every POLL_CYCLES+accept+done.
// Backpressure: holds cmd_valid and all cmd_* fields stable until cmd_ready; no timeout.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   start             1-cycle (re)initialise request, honoured only in IDLE or ERROR
//   cam_reset         camera reset, active-low
//   cmd_valid/ready   command handshake to the byte-level I2C master
//   cmd_rw/addr/reg/data  command fields (rw: 0 write, 1 read)
//   cmd_done/nack     completion pulse from the master, nack qualified by done
//   configured        config table fully written
//   frame_strobe      1-cycle pulse per successful position read
//   error             sticky, set when MAX_RETRY consecutive NACKs are seen
module cam_sequencer #(
  parameter int          RESET_CYCLES  = 16,
  parameter int          SETTLE_CYCLES = 100,
  parameter int          POLL_CYCLES   = 1000,
  parameter logic [6:0]  DEV_ADDR      = 7'h58,
  parameter int          MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       cam_reset,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_rw,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_data,
  input  logic       cmd_done,
  input  logic       cmd_nack,
  output logic       configured,
  output logic       frame_strobe,
  output logic       error
);

  localparam int MAX_A   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > POLL_CYCLES) ? MAX_A : POLL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  // Terminal values: a count of N completes on the N-th cycle in the state.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_LAST   = CNT_W'(POLL_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST    = RTY_W'(MAX_RETRY - 1);
  localparam logic [2:0]       LAST_IDX    = 3'd5;
  localparam logic [7:0]       POS_REG     = 8'h36;

  typedef enum logic [3:0] {
    IDLE, RST, SETTLE, WR, WR_WAIT, POLL_WAIT, RD, RD_WAIT, ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry;
  logic [2:0]       idx;

  // Camera configuration table: {register, data}.
  function automatic logic [15:0] table_entry(input logic [2:0] i);
    case (i)
      3'd0:    table_entry = 16'h3001;
      3'd1:    table_entry = 16'h3008;
      3'd2:    table_entry = 16'h0690;
      3'd3:    table_entry = 16'h08C0;
      3'd4:    table_entry = 16'h1A40;
      default: table_entry = 16'h3333;
    endcase
  endfunction

  assign cmd_addr = DEV_ADDR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      retry        <= '0;
      idx          <= '0;
      cam_reset    <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_rw       <= 1'b0;
      cmd_reg      <= 8'h00;
      cmd_data     <= 8'h00;
      configured   <= 1'b0;
      frame_strobe <= 1'b0;
      error        <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RST;
            cnt   <= '0;
            idx   <= '0;
            retry <= '0;
          end
        end

        RST: begin
          if (cnt == RST_LAST) begin
            state     <= SETTLE;
            cnt       <= '0;
            cam_reset <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state                <= WR;
            cnt                  <= '0;
            idx                  <= 3'd0;
            cmd_valid            <= 1'b1;
            cmd_rw               <= 1'b0;
            {cmd_reg, cmd_data}  <= table_entry(3'd0);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WR: begin
          if (cmd_ready) begin
            state     <= WR_WAIT;
            cmd_valid <= 1'b0;
          end
        end

        WR_WAIT: begin
          if (cmd_done) begin
            if (!cmd_nack) begin
              retry <= '0;
              if (idx == LAST_IDX) begin
                state      <= POLL_WAIT;
                cnt        <= '0;
                configured <= 1'b1;
              end else begin
                state               <= WR;
                idx                 <= idx + 3'd1;
                cmd_valid           <= 1'b1;
                {cmd_reg, cmd_data} <= table_entry(idx + 3'd1);
              end
            end else if (retry == RTY_LAST) begin
              state     <= ERROR;
              error     <= 1'b1;
              cam_reset <= 1'b0;
              cmd_valid <= 1'b0;
            end else begin
              // Re-issue the same entry; cmd fields still hold it.
              retry     <= retry + RTY_W'(1);
              state     <= WR;
              cmd_valid <= 1'b1;
            end
          end
        end

        POLL_WAIT: begin
          if (cnt == POLL_LAST) begin
            state     <= RD;
            cnt       <= '0;
            cmd_valid <= 1'b1;
            cmd_rw    <= 1'b1;
            cmd_reg   <= POS_REG;
            cmd_data  <= 8'h00;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RD: begin
          if (cmd_ready) begin
            state     <= RD_WAIT;
            cmd_valid <= 1'b0;
          end
        end

        RD_WAIT: begin
          if (cmd_done) begin
            cnt <= '0;
            if (!cmd_nack) begin
              frame_strobe <= 1'b1;
              retry        <= '0;
              state        <= POLL_WAIT;
            end else if (retry == RTY_LAST) begin
              state     <= ERROR;
              error     <= 1'b1;
              cam_reset <= 1'b0;
              cmd_valid <= 1'b0;
            end else begin
              // Read NACKs accumulate across poll periods; next read after the normal delay.
              retry <= retry + RTY_W'(1);
              state <= POLL_WAIT;
            end
          end
        end

        ERROR: begin
          cmd_valid <= 1'b0;
          cam_reset <= 1'b0;
          if (start) begin
            state      <= RST;
            cnt        <= '0;
            idx        <= '0;
            retry      <= '0;
            error      <= 1'b0;
            configured <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_sequencer.sv
// Purpose : self-checking bench for cam_sequencer with a scoreboarded I2C master model.
// Latency : master accepts immediately (except one scripted stall) and answers done two cycles after accept.
// Backpressure: a 5-cycle cmd_ready stall is applied to config entry 2 on the first bring-up.
module tb_cam_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cam_reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       cmd_done;
  logic       cmd_nack;
  logic       configured;
  logic       frame_strobe;
  logic       error;

  cam_sequencer #(
    .RESET_CYCLES (4),
    .SETTLE_CYCLES(8),
    .POLL_CYCLES  (20),
    .DEV_ADDR     (7'h58),
    .MAX_RETRY    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cam_reset   (cam_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_reg     (cmd_reg),
    .cmd_data    (cmd_data),
    .cmd_done    (cmd_done),
    .cmd_nack    (cmd_nack),
    .configured  (configured),
    .frame_strobe(frame_strobe),
    .error       (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       rw;
    logic [7:0] rg;
    logic [7:0] dt;
  } cmd_t;

  cmd_t exp_q[$];
  bit   nack_q[$];
  int   strobe_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [15:0] tbl [0:5] = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};

  // master model state
  int stall_left = 0;
  bit stall_arm  = 1'b0;
  int d_cnt      = 0;
  bit pend_nack  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected write sequence; entry `rep_idx` appears rep_extra extra times (NACK retries).
  task automatic push_writes(input int rep_idx, input int rep_extra);
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r <= ((i == rep_idx) ? rep_extra : 0); r++)
        exp_q.push_back({1'b0, tbl[i]});
    end
  endtask

  task automatic push_read();
    exp_q.push_back({1'b1, 8'h36, 8'h00});
  endtask

  // I2C master model: acts 1 time unit after each rising edge.
  initial begin
    cmd_ready = 1'b1;
    cmd_done  = 1'b0;
    cmd_nack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0) begin
          cmd_done = 1'b1;
          cmd_nack = pend_nack;
        end
      end
      if (stall_arm && cmd_valid && cmd_reg == 8'h06) begin
        stall_left = 5;
        stall_arm  = 1'b0;
      end
      if (stall_left > 0) begin
        cmd_ready = 1'b0;
        stall_left--;
      end else begin
        cmd_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        d_cnt     = 2;
        pend_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
      end
    end
  end

  // Monitor / scoreboard, samples on the falling edge.
  initial begin
    bit   hold_prev = 1'b0;
    bit   prev_fs   = 1'b0;
    cmd_t e;
    forever begin
      @(negedge clk);
      if (hold_prev) chk("hold_valid", 32'(cmd_valid), 32'd1);
      if (cmd_valid && !cmd_ready && exp_q.size() > 0)
        chk("hold_fields", 32'({cmd_addr, cmd_rw, cmd_reg, cmd_data}), 32'({7'h58, exp_q[0]}));
      hold_prev = cmd_valid && !cmd_ready;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_cmd: got rw=%0d reg=%h data=%h, required no command (cycle %0d)",
                   cmd_rw, cmd_reg, cmd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", 32'({cmd_addr, cmd_rw, cmd_reg, cmd_data}), 32'({7'h58, e}));
        end
      end
      if (prev_fs) chk("strobe_width", 32'(frame_strobe), 32'd0);
      if (frame_strobe) strobe_q.push_back(cyc);
      prev_fs = frame_strobe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          c0;
    logic [12:0] pat;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_cam_reset",  32'(cam_reset),    32'd0);
    chk("rst_cmd_valid",  32'(cmd_valid),    32'd0);
    chk("rst_cmd_rw",     32'(cmd_rw),       32'd0);
    chk("rst_cmd_reg",    32'(cmd_reg),      32'd0);
    chk("rst_cmd_data",   32'(cmd_data),     32'd0);
    chk("rst_configured", 32'(configured),   32'd0);
    chk("rst_strobe",     32'(frame_strobe), 32'd0);
    chk("rst_error",      32'(error),        32'd0);
    while (cyc < 2) @(negedge clk);
    reset = 1'b0;

    // Bring-up: entry 3 NACKed twice; then reads 1,2 ACK and reads 3,4,5 NACK.
    push_writes(3, 2);
    for (int i = 0; i < 5; i++) push_read();
    pat = 13'b0001100000111;
    for (int i = 12; i >= 0; i--) nack_q.push_back(pat[i]);
    stall_arm = 1'b1;

    while (cyc < 10) @(negedge clk);
    chk("idle_cam_reset", 32'(cam_reset), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 11; c <= 22; c++) begin
      chk("cam_reset_seq", 32'(cam_reset), 32'(cyc >= 15));
      chk("no_cmd_early",  32'(cmd_valid), 32'd0);
      @(negedge clk);
    end
    chk("first_cmd_cycle", 32'(cmd_valid), 32'd1);

    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (configured) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("configured_rise", 32'(ok), 32'd1);
    c0 = cyc;
    chk("no_error_after_retry", 32'(error), 32'd0);

    // start in POLL_WAIT must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_start_cam", 32'(cam_reset),  32'd1);
    chk("ignored_start_cfg", 32'(configured), 32'd1);

    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (error) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("error_rise",      32'(ok),              32'd1);
    chk("err_cam_reset",   32'(cam_reset),       32'd0);
    chk("err_cmd_valid",   32'(cmd_valid),       32'd0);
    chk("strobe_count",    32'(strobe_q.size()), 32'd2);
    chk("strobe1_cycle",   32'((strobe_q.size() > 0) ? strobe_q[0] : -1), 32'(c0 + 23));
    chk("strobe2_cycle",   32'((strobe_q.size() > 1) ? strobe_q[1] : -1), 32'(c0 + 46));
    chk("sb_empty_1",      32'(exp_q.size()),    32'd0);
    repeat (20) @(negedge clk);
    chk("error_sticky",    32'(error),           32'd1);

    // Recovery from ERROR
    push_writes(-1, 0);
    push_read();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("recover_error",   32'(error),      32'd0);
    chk("recover_cfg",     32'(configured), 32'd0);
    chk("recover_cam",     32'(cam_reset),  32'd0);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (strobe_q.size() == 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("recover_strobe",  32'(ok),         32'd1);
    chk("recover_cfg_set", 32'(configured), 32'd1);

    // Async reset between edges while polling
    #2;
    reset = 1'b1;
    #1;
    chk("areset_cfg",    32'(configured),   32'd0);
    chk("areset_cam",    32'(cam_reset),    32'd0);
    chk("areset_strobe", 32'(frame_strobe), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset during a write (entry 2 presented)
    exp_q.push_back({1'b0, tbl[0]});
    exp_q.push_back({1'b0, tbl[1]});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (cmd_valid && cmd_reg == 8'h06) begin ok = 1'b1; break; end
    end
    chk("reach_entry2", 32'(ok), 32'd1);
    reset = 1'b1;
    #1;
    chk("wr_reset_valid", 32'(cmd_valid),  32'd0);
    chk("wr_reset_cfg",   32'(configured), 32'd0);
    chk("wr_reset_cam",   32'(cam_reset),  32'd0);
    chk("wr_reset_reg",   32'(cmd_reg),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle_after_reset_valid", 32'(cmd_valid),     32'd0);
    chk("idle_after_reset_cam",   32'(cam_reset),     32'd0);
    chk("sb_empty_2",             32'(exp_q.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_sequencer.md
Name: cam_sequencer

Overview:
- Controls bring-up and polling of the IR camera over a shared byte-level I2C master.
- After `start`: pulses the camera reset, waits for the camera to settle, then writes a fixed 6-entry configuration table.
- Then issues periodic position-register reads and flags each completed read with `frame_strobe` for the position decoder.
- Sits between the top level (`start`) and the I2C master (cmd/ready/done handshake).

Parameters:
- RESET_CYCLES, 16, cycles `cam_reset` is held low after start.
- SETTLE_CYCLES, 100, cycles waited after `cam_reset` release before the first write.
- POLL_CYCLES, 1000, cycles spent in POLL_WAIT before each read is issued.
- DEV_ADDR, 7'h58, camera 7-bit I2C address.
- MAX_RETRY, 3, consecutive NACKs tolerated on one command before ERROR.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle request to (re)initialise; honoured only in IDLE or ERROR
- cam_reset  out  1  camera reset, active-low (0 = camera held in reset)
- cmd_valid  out  1  command request to I2C master
- cmd_ready  in  1  master accepts the command when cmd_valid && cmd_ready
- cmd_rw  out  1  0 = write, 1 = read
- cmd_addr  out  7  device address, always DEV_ADDR
- cmd_reg  out  8  register address
- cmd_data  out  8  write data; 0 for reads
- cmd_done  in  1  1-cycle pulse: command finished
- cmd_nack  in  1  valid with cmd_done; 1 = device NACK
- configured  out  1  init table fully written
- frame_strobe  out  1  1-cycle pulse per successful poll read
- error  out  1  sticky; set on entry to ERROR

Behaviour:
- Reset: the clock and asynchronous active-high reset are fixed as above.
  - Async reset forces state IDLE and zeroes all counters.
  - Output values in reset: cam_reset=0, cmd_valid=0, cmd_rw=0, cmd_reg=0, cmd_data=0, configured=0, frame_strobe=0, error=0.
  - Reset mid-transaction abandons the command immediately; the master is responsible for its own recovery.
- States: IDLE, RST, SETTLE, WR, WR_WAIT, POLL_WAIT, RD, RD_WAIT, ERROR.
- Transitions:
  - IDLE: `start` -> RST. cam_reset=0.
  - RST: holds RESET_CYCLES cycles -> SETTLE. cam_reset=1 from the first SETTLE cycle onward.
  - SETTLE: holds SETTLE_CYCLES cycles -> WR with idx=0.
  - WR: cmd_valid=1 with cmd_rw=0, cmd_reg=TABLE[idx].reg, cmd_data=TABLE[idx].data.
    - All cmd_* fields stay stable while cmd_valid=1.
    - On the accept cycle -> WR_WAIT; cmd_valid=0 from the next cycle.
  - WR_WAIT, on cmd_done:
    - cmd_nack=0: retry=0; idx+1, or POLL_WAIT if idx==5. configured=1 from the first POLL_WAIT cycle and held until reset or restart.
    - cmd_nack=1: retry+1; if retry reaches MAX_RETRY -> ERROR, else back to WR with the same idx.
  - POLL_WAIT: counts POLL_CYCLES cycles -> RD.
  - RD: cmd_valid=1, cmd_rw=1, cmd_reg=8'h36, cmd_data=0. On accept -> RD_WAIT.
  - RD_WAIT, on cmd_done:
    - cmd_nack=0: frame_strobe=1 for exactly the next cycle; retry=0 -> POLL_WAIT.
    - cmd_nack=1: no strobe; retry+1; ERROR at MAX_RETRY, else -> POLL_WAIT (the normal poll delay applies).
  - ERROR: error=1, cmd_valid=0, cam_reset=0. `start` clears error and configured -> RST.
- TABLE (reg, data), idx 0..5: (30,01) (30,08) (06,90) (08,C0) (1A,40) (33,33).
- Boundary conditions:
  - cmd_done outside WR_WAIT/RD_WAIT is ignored, including a done in the same cycle as accept.
  - `start` in any state other than IDLE/ERROR is ignored; a running sequence is not restarted.
  - cmd_ready held low: stay in WR/RD indefinitely with cmd_valid=1; no timeout.
  - Counters are wide enough for each parameter value; a count completes after exactly N cycles in the state.
  - retry resets to 0 on every successful command.
  - retry counts consecutive NACKs on one command; read retries accumulate across poll periods.

Test Plan (RESET_CYCLES=4, SETTLE_CYCLES=8, POLL_CYCLES=20, MAX_RETRY=3; master model: ready=1, done+nack=0 two cycles after accept):
- Bring-up: `start` at cycle 10 -> cam_reset=0 through cycle 14, 1 from cycle 15; first cmd_valid at cycle 23 with reg=30, data=01, addr=58; six writes in TABLE order; configured=1 after the sixth done.
- Handshake stall: cmd_ready=0 for 5 cycles during entry 2 -> cmd_valid stays 1 with reg=06, data=90 unchanged; one accept only.
- Polling: after configured, reads with reg=36, rw=1 are issued every POLL_CYCLES+accept+done cycles -> one 1-cycle frame_strobe per read.
- NACK retry: entry 3 NACKed twice then ACKed -> reg=08 issued 3 times, no error. Three consecutive NACKs -> error=1, cam_reset=0, cmd_valid=0.
- Recovery / ignored start: `start` in ERROR -> error=0, full sequence repeats; `start` pulsed in POLL_WAIT -> no effect.
- Async reset mid-write (reset high between clock edges) -> immediately cmd_valid=0, configured=0, cam_reset=0; state IDLE.
